store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 25 ++
 rtl/store_buffer_fifo.sv | 64 ++++++
 rtl/store_buffer.sv | 73 +++++++
 tb/tb_store_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: default depth, entry record,
// and the byte-lane merge used for single-cycle read-modify-write drains.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  // Lanes with be set take the new store data; the rest keep the memory word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] new_data,
                                              input logic [3:0]  be,
                                              input logic [31:0] old_data);
    logic [31:0] r;
    r = old_data;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular pending-store FIFO: head/tail pointers, occupancy count and a
// per-slot valid bit so the parent can compare load addresses against entries.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  sb_entry_t    push_entry,
  input  logic         pop,
  output sb_entry_t    head_entry,
  output logic [31:2]  entry_addr [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic         full,
  output logic         empty
);

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits and count own occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem[i].addr;
  end

  assign head_entry = mem[head];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and a single-port data memory:
// queues stores, drains them with byte-lane RMW, and stalls conflicting loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [31:2] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:2] ld_addr,
  output logic        ld_stall,
  output logic [31:2] dm_A,
  output logic [31:0] dm_D,
  output logic        dm_E,
  input  logic [31:0] dm_O,
  output logic        sb_empty
);

  // Handshakes: a store transfers on any cycle with st_req && st_ready, and the
  // requester holds st_req and its payload stable until then; a load completes
  // on any cycle with ld_req && !ld_stall, otherwise it is held and retried.

  sb_entry_t        head_entry;
  sb_entry_t        new_entry;
  logic [31:2]      entry_addr [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             hit;

  assign st_ready  = !full;
  assign push      = st_req && st_ready && (st_be != 4'b0000);
  assign new_entry = '{addr: st_addr, data: st_data, be: st_be};

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entry_addr[i] == ld_addr)) hit = 1'b1;
    end
  end

  // Drain whenever the port is free, a load would read a word still queued
  // here, or the buffer is full and must make room.
  assign pop = !empty && (!ld_req || hit || full);

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (new_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entry_addr (entry_addr),
    .valid      (valid),
    .full       (full),
    .empty      (empty)
  );

  assign dm_E     = pop;
  assign dm_A     = pop ? head_entry.addr : ld_addr;
  assign dm_D     = merge_lanes(head_entry.data, head_entry.be, dm_O);
  assign ld_stall = ld_req && pop;
  assign sb_empty = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table for single-cycle behaviour,
// plus hand sequences for pointer wrap and asynchronous reset mid-drain.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_req;
  logic [31:2] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_req;
  logic [31:2] ld_addr;
  logic        ld_stall;
  logic [31:2] dm_a;
  logic [31:0] dm_d;
  logic        dm_e;
  logic [31:0] dm_o;
  logic        sb_empty;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  store_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .st_ready (st_ready),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_stall (ld_stall),
    .dm_A     (dm_a),
    .dm_D     (dm_d),
    .dm_E     (dm_e),
    .dm_O     (dm_o),
    .sb_empty (sb_empty)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_o = mem[dm_a[9:2]];
  always @(posedge clk) begin
    if (dm_e) mem[dm_a[9:2]] <= dm_d;
  end

  typedef struct {
    logic        st_req;
    logic [31:2] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        ld_req;
    logic [31:2] ld_addr;
    logic        e_ready;
    logic        e_stall;
    logic        e_dme;
    logic [31:2] e_dma;
    logic [31:0] e_dmd;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sr, input logic [31:2] sa, input logic [31:0] sd,
                              input logic [3:0] sbe, input logic lr, input logic [31:2] la,
                              input logic er, input logic es, input logic ee,
                              input logic [31:2] ea, input logic [31:0] ed, input logic em);
    vec_t v;
    v.st_req = sr; v.st_addr = sa; v.st_data = sd; v.st_be = sbe;
    v.ld_req = lr; v.ld_addr = la;
    v.e_ready = er; v.e_stall = es; v.e_dme = ee; v.e_dma = ea; v.e_dmd = ed; v.e_empty = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic sr, input logic [31:2] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic lr, input logic [31:2] la);
    st_req = sr; st_addr = sa; st_data = sd; st_be = sbe;
    ld_req = lr; ld_addr = la;
  endtask

  task automatic check_outs(input string tag, input logic er, input logic es, input logic ee,
                            input logic [31:2] ea, input logic [31:0] ed, input logic em);
    chk({tag, ".st_ready"}, 32'(st_ready), 32'(er));
    chk({tag, ".ld_stall"}, 32'(ld_stall), 32'(es));
    chk({tag, ".dm_E"},     32'(dm_e),     32'(ee));
    chk({tag, ".dm_A"},     32'(dm_a),     32'(ea));
    chk({tag, ".sb_empty"}, 32'(sb_empty), 32'(em));
    if (ee) chk({tag, ".dm_D"}, dm_d, ed);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 'h0, 0, 0, 1, 'h3);

    // Reset state: empty, ready, no write, no stall, address follows load
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 1, 0, 0, 'h3, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 'h0, 0, 0, 0, 'h3);

    // Full-word store then drain
    vecs.push_back(mk(1, 'h40, 32'hDEADBEEF, 4'hF, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    // Partial store merges with the existing memory word
    vecs.push_back(mk(1, 'h50, 32'h11223344, 4'hF, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'h50, 32'h11223344, 0));
    vecs.push_back(mk(1, 'h50, 32'h0000AA00, 4'h2, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'h50, 32'h1122AA44, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    // be == 0 is accepted and dropped
    vecs.push_back(mk(1, 'h60, 32'h12345678, 4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    // Load hitting a pending store forces a drain and a one-cycle stall
    vecs.push_back(mk(1, 'h80, 32'hCAFEF00D, 4'hF, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 1, 'h80, 1, 1, 1, 'h80, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 1, 'h80, 1, 0, 0, 'h80, 0, 1));
    // Load to a different word takes priority over a non-full buffer
    vecs.push_back(mk(1, 'h90, 32'h00000001, 4'hF, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 1, 'h91, 1, 0, 0, 'h91, 0, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'h90, 32'h00000001, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));
    // Fill to DEPTH under continuous unrelated loads; full forces a drain
    vecs.push_back(mk(1, 'hA0, 32'hA0000000, 4'hF, 1, 'hFF, 1, 0, 0, 'hFF, 0, 1));
    vecs.push_back(mk(1, 'hA1, 32'hA0000001, 4'hF, 1, 'hFF, 1, 0, 0, 'hFF, 0, 0));
    vecs.push_back(mk(1, 'hA2, 32'hA0000002, 4'hF, 1, 'hFF, 1, 0, 0, 'hFF, 0, 0));
    vecs.push_back(mk(1, 'hA3, 32'hA0000003, 4'hF, 1, 'hFF, 1, 0, 0, 'hFF, 0, 0));
    vecs.push_back(mk(1, 'hA4, 32'hA0000004, 4'hF, 1, 'hFF, 0, 1, 1, 'hA0, 32'hA0000000, 0));
    vecs.push_back(mk(1, 'hA4, 32'hA0000004, 4'hF, 1, 'hFF, 1, 0, 0, 'hFF, 0, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 1, 'hFF, 0, 1, 1, 'hA1, 32'hA0000001, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'hA2, 32'hA0000002, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'hA3, 32'hA0000003, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 1, 'hA4, 32'hA0000004, 0));
    vecs.push_back(mk(0, 'h0,  0,            4'h0, 0, 'h3,  1, 0, 0, 'h3,  0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st_req, vecs[i].st_addr, vecs[i].st_data, vecs[i].st_be,
            vecs[i].ld_req, vecs[i].ld_addr);
      #1 check_outs($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_dme,
                    vecs[i].e_dma, vecs[i].e_dmd, vecs[i].e_empty);
    end

    // Wrap: one lead store, then 9 cycles of simultaneous enqueue and drain
    @(negedge clk);
    drive(1, 'hC0, 32'hD0000000, 4'hF, 0, 'h3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      drive(1, 30'('hC0 + k), 32'hD0000000 + 32'(k), 4'hF, 0, 'h3);
      #1 check_outs($sformatf("wrap%0d", k), 1, 0, 1, 30'('hC0 + k - 1),
                    32'hD0000000 + 32'(k - 1), 0);
    end
    @(negedge clk);
    drive(0, 'h0, 0, 0, 0, 'h3);
    #1 check_outs("wrap_last", 1, 0, 1, 'hC9, 32'hD0000009, 0);
    @(negedge clk);
    #1 check_outs("wrap_empty", 1, 0, 0, 'h3, 0, 1);

    // Reset mid-drain with three entries pending
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 30'('hE0 + k), 32'hE0000000 + 32'(k), 4'hF, 1, 'hFF);
    end
    @(negedge clk);
    drive(0, 'h0, 0, 0, 0, 'hFF);
    #1 check_outs("pre_rst", 1, 0, 1, 'hE0, 32'hE0000000, 0);
    #2 reset = 1'b0;
    #1 check_outs("in_rst", 1, 0, 0, 'hFF, 0, 1);
    drive(0, 'h0, 0, 0, 1, 'hE0);
    #1 check_outs("in_rst_ld", 1, 0, 0, 'hE0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 'h0, 0, 0, 0, 'h3);
    #1 check_outs("post_rst0", 1, 0, 0, 'h3, 0, 1);
    @(negedge clk);
    #1 check_outs("post_rst1", 1, 0, 0, 'h3, 0, 1);
    chk("post_rst_mem_e0", mem[8'hE0], 32'h0);
    chk("post_rst_mem_e1", mem[8'hE1], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
